// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin front end for a single I2C master: latches the
// winner's address/rw/data, pulses the master enable and tracks busy with timeouts.
module i2c_master_arbiter #(
    parameter int unsigned ENABLE_CYCLES = 8,
    parameter int unsigned BUSY_TIMEOUT  = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic [6:0] i_addr0,
    input  logic [6:0] i_addr1,
    input  logic       i_rw0,
    input  logic       i_rw1,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    output logic [1:0] o_grant,
    output logic [1:0] o_done,
    output logic       o_err,
    output logic       o_m_enable,
    output logic [6:0] o_m_address,
    output logic       o_m_rw,
    output logic [7:0] o_m_data,
    input  logic       i_m_busy
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(ENABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          seen, seen_nx;
    logic          err_flag, err_nx;
    logic          last, last_nx;
    logic          pick1;
    logic [1:0]    grant_nx;
    logic [6:0]    addr_nx;
    logic          rw_nx;
    logic [7:0]    data_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            seen        <= 1'b0;
            err_flag    <= 1'b0;
            last        <= 1'b1;
            o_grant     <= '0;
            o_m_address <= '0;
            o_m_rw      <= 1'b0;
            o_m_data    <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            seen        <= seen_nx;
            err_flag    <= err_nx;
            last        <= last_nx;
            o_grant     <= grant_nx;
            o_m_address <= addr_nx;
            o_m_rw      <= rw_nx;
            o_m_data    <= data_nx;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign pick1   = (i_req == 2'b11) ? ~last : i_req[1];

    // cnt measures cycles since launch start until busy is seen, then is
    // restarted at 1 so it measures cycles since busy was first sampled high.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seen_nx  = seen;
        err_nx   = err_flag;
        last_nx  = last;
        grant_nx = o_grant;
        addr_nx  = o_m_address;
        rw_nx    = o_m_rw;
        data_nx  = o_m_data;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    state_nx = LAUNCH;
                    grant_nx = pick1 ? 2'b10 : 2'b01;
                    addr_nx  = pick1 ? i_addr1 : i_addr0;
                    rw_nx    = pick1 ? i_rw1 : i_rw0;
                    data_nx  = pick1 ? i_data1 : i_data0;
                    cnt_nx   = '0;
                    seen_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            LAUNCH: begin
                if (i_m_busy) begin
                    state_nx = ACTIVE;
                    seen_nx  = 1'b1;
                    cnt_nx   = CNT_ONE;
                end else if (cnt == TMO_LAST) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt == EN_LAST) state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!seen && i_m_busy) begin
                    seen_nx = 1'b1;
                    cnt_nx  = CNT_ONE;
                end else if (seen && !i_m_busy) begin
                    state_nx = DONE;
                end else if (cnt == TMO_LAST) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            DONE: begin
                state_nx = IDLE;
                grant_nx = '0;
                last_nx  = o_grant[1];
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_m_enable = (state == LAUNCH);
    assign o_done     = (state == DONE) ? o_grant : 2'b00;
    assign o_err      = (state == DONE) && err_flag;

endmodule
